// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED controller: DATA/SET/CLR/TOG/BLINK_EN/PERIOD registers
// with a per-channel blink mask driven by a shared down-counting divider.
module led_mmio_ctrl #(
    parameter int          LED_W     = 24,
    parameter logic [11:0] BASE_ADDR = 12'h060,
    parameter int          DIV_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dv_wr_e,
    input  logic             dv_rd_e,
    input  logic [11:0]      dv_addr,
    input  logic [31:0]      data_fromcpu,
    output logic [31:0]      data_tocpu,
    output logic [LED_W-1:0] led
);

    localparam logic [11:0] A_DATA  = BASE_ADDR;
    localparam logic [11:0] A_SET   = BASE_ADDR + 12'h004;
    localparam logic [11:0] A_CLR   = BASE_ADDR + 12'h008;
    localparam logic [11:0] A_TOG   = BASE_ADDR + 12'h00C;
    localparam logic [11:0] A_BLINK = BASE_ADDR + 12'h010;
    localparam logic [11:0] A_PER   = BASE_ADDR + 12'h014;

    logic [LED_W-1:0] data_reg;
    logic [LED_W-1:0] blink_en;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] cnt;
    logic             phase;

    logic             sel_data;
    logic             sel_set;
    logic             sel_clr;
    logic             sel_tog;
    logic             sel_blink;
    logic             sel_per;
    logic             sel_any;

    logic [LED_W-1:0] wdata;
    logic [DIV_W-1:0] pdata;
    logic [LED_W-1:0] next_data;
    logic [LED_W-1:0] next_blink;
    logic [DIV_W-1:0] next_period;
    logic [DIV_W-1:0] next_cnt;
    logic             next_phase;
    logic [31:0]      rd_val;

    assign sel_data  = (dv_addr == A_DATA);
    assign sel_set   = (dv_addr == A_SET);
    assign sel_clr   = (dv_addr == A_CLR);
    assign sel_tog   = (dv_addr == A_TOG);
    assign sel_blink = (dv_addr == A_BLINK);
    assign sel_per   = (dv_addr == A_PER);
    assign sel_any   = sel_data | sel_set | sel_clr |
                       sel_tog | sel_blink | sel_per;

    assign wdata = data_fromcpu[LED_W-1:0];
    assign pdata = data_fromcpu[DIV_W-1:0];

    always_comb begin
        next_data   = data_reg;
        next_blink  = blink_en;
        next_period = period;
        if (dv_wr_e) begin
            unique case (1'b1)
                sel_data:  next_data   = wdata;
                sel_set:   next_data   = data_reg | wdata;
                sel_clr:   next_data   = data_reg & ~wdata;
                sel_tog:   next_data   = data_reg ^ wdata;
                sel_blink: next_blink  = wdata;
                sel_per:   next_period = pdata;
                default:   next_data   = data_reg;
            endcase
        end
    end

    // A PERIOD write restarts the blink cleanly in the off-mask phase.
    always_comb begin
        next_cnt   = '0;
        next_phase = 1'b0;
        if (dv_wr_e && sel_per) begin
            next_cnt   = pdata;
            next_phase = 1'b0;
        end else if (period != '0) begin
            if (cnt == '0) begin
                next_cnt   = period;
                next_phase = ~phase;
            end else begin
                next_cnt   = cnt - DIV_W'(1);
                next_phase = phase;
            end
        end
    end

    // SET/CLR/TOG alias DATA on reads.
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_data:  rd_val = 32'(data_reg);
            sel_set:   rd_val = 32'(data_reg);
            sel_clr:   rd_val = 32'(data_reg);
            sel_tog:   rd_val = 32'(data_reg);
            sel_blink: rd_val = 32'(blink_en);
            sel_per:   rd_val = 32'(period);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg   <= '0;
            blink_en   <= '0;
            period     <= '0;
            cnt        <= '0;
            phase      <= 1'b0;
            led        <= '0;
            data_tocpu <= '0;
        end else begin
            data_reg <= next_data;
            blink_en <= next_blink;
            period   <= next_period;
            cnt      <= next_cnt;
            phase    <= next_phase;
            led      <= next_data & ~(next_blink & {LED_W{next_phase}});
            if (dv_rd_e && sel_any) begin
                data_tocpu <= rd_val;
            end
        end
    end

endmodule
